// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: own baud tick generator, 3-sample majority vote,
// configurable data/parity/stop format, valid/ack handshake with per-frame error flags.
module uart_rx_os #(
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_uart_rx,
  input  logic                 i_rx_ack,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_rx_busy,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun_err
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int SMP_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  // state | meaning: IDLE wait for edge, START confirm start bit, DATA shift bits,
  // PARITY check parity bit, STOP accumulate stop bits and commit on the last one
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_s1, r_s2, r_s3;
  logic [DIV_W-1:0]     r_div;
  logic [SMP_W-1:0]     r_smp;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_v0, r_v1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_stop_ok;

  logic w_fall, w_tick, w_wrap, w_smp_lo, w_smp_mid, w_dec, w_vote;
  logic w_last_data, w_last_stop, w_par_exp, w_commit;

  assign w_fall      = r_s3 & ~r_s2;
  assign w_tick      = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_wrap      = w_tick && (r_smp == SMP_W'(OVERSAMPLE - 1));
  assign w_smp_lo    = w_tick && (r_smp == SMP_W'(OVERSAMPLE/2 - 1));
  assign w_smp_mid   = w_tick && (r_smp == SMP_W'(OVERSAMPLE/2));
  assign w_dec       = w_tick && (r_smp == SMP_W'(OVERSAMPLE/2 + 1));
  assign w_vote      = (r_v0 & r_v1) | (r_v0 & r_s2) | (r_v1 & r_s2);
  assign w_last_data = (r_idx == IDX_W'(DATA_BITS - 1));
  assign w_last_stop = (r_idx == IDX_W'(STOP_BITS - 1));
  assign w_par_exp   = (PARITY == 1) ? ~(^r_shift) : (^r_shift);
  assign o_rx_busy   = (r_state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE:   if (w_fall) w_next = S_START;
      S_START: begin
        if (w_dec && w_vote) w_next = S_IDLE;
        else if (w_wrap)     w_next = S_DATA;
      end
      S_DATA:   if (w_wrap && w_last_data) w_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_wrap) w_next = S_STOP;
      S_STOP: begin
        if (w_dec && w_last_stop) begin
          w_next   = S_IDLE;
          w_commit = 1'b1;
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1          <= 1'b1;
      r_s2          <= 1'b1;
      r_s3          <= 1'b1;
      r_div         <= '0;
      r_smp         <= '0;
      r_idx         <= '0;
      r_v0          <= 1'b1;
      r_v1          <= 1'b1;
      r_shift       <= '0;
      r_par_err     <= 1'b0;
      r_stop_ok     <= 1'b1;
      o_rx_data     <= '0;
      o_rx_valid    <= 1'b0;
      o_frame_err   <= 1'b0;
      o_parity_err  <= 1'b0;
      o_overrun_err <= 1'b0;
    end else begin
      r_s1 <= i_uart_rx;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      if (r_state == S_IDLE) begin
        r_div <= '0;
        r_smp <= '0;
        r_idx <= '0;
        if (w_fall) begin
          r_stop_ok <= 1'b1;
          r_par_err <= 1'b0;
        end
      end else begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
        if (w_tick) r_smp <= w_wrap ? '0 : r_smp + 1'b1;
      end

      if (w_smp_lo)  r_v0 <= r_s2;
      if (w_smp_mid) r_v1 <= r_s2;

      if (r_state == S_DATA) begin
        if (w_dec)  r_shift[r_idx] <= w_vote;
        if (w_wrap) r_idx <= w_last_data ? '0 : r_idx + 1'b1;
      end

      if (r_state == S_PARITY && w_dec) r_par_err <= w_vote ^ w_par_exp;

      if (r_state == S_STOP) begin
        if (w_dec)  r_stop_ok <= r_stop_ok & w_vote;
        if (w_wrap) r_idx <= r_idx + 1'b1;
      end

      // a commit coinciding with ack wins: the new character stays valid
      if (w_commit) begin
        o_rx_data     <= r_shift;
        o_frame_err   <= ~(r_stop_ok & w_vote);
        o_parity_err  <= r_par_err;
        o_overrun_err <= o_rx_valid & ~i_rx_ack;
        o_rx_valid    <= 1'b1;
      end else if (i_rx_ack) begin
        o_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: four builds (8N1, 8E1, 8O1, 8N2) on separate lines; every
// commit is checked against a scoreboard queue filled when the frame is sent.
module tb_uart_rx_os;
  localparam int B = 64;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] line  = 4'hF;
  logic [3:0] ack   = 4'h0;
  wire  [7:0] data_w [4];
  wire  [3:0] valid_w, busy_w, fe_w, pe_w, oe_w;

  int total = 0;
  int bad   = 0;
  int lat;
  logic [10:0] exp_q [4][$];

  always #5 clk = ~clk;

  uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(line[0]), .i_rx_ack(ack[0]),
    .o_rx_data(data_w[0]), .o_rx_valid(valid_w[0]), .o_rx_busy(busy_w[0]),
    .o_frame_err(fe_w[0]), .o_parity_err(pe_w[0]), .o_overrun_err(oe_w[0]));

  uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(line[1]), .i_rx_ack(ack[1]),
    .o_rx_data(data_w[1]), .o_rx_valid(valid_w[1]), .o_rx_busy(busy_w[1]),
    .o_frame_err(fe_w[1]), .o_parity_err(pe_w[1]), .o_overrun_err(oe_w[1]));

  uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(line[2]), .i_rx_ack(ack[2]),
    .o_rx_data(data_w[2]), .o_rx_valid(valid_w[2]), .o_rx_busy(busy_w[2]),
    .o_frame_err(fe_w[2]), .o_parity_err(pe_w[2]), .o_overrun_err(oe_w[2]));

  uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(line[3]), .i_rx_ack(ack[3]),
    .o_rx_data(data_w[3]), .o_rx_valid(valid_w[3]), .o_rx_busy(busy_w[3]),
    .o_frame_err(fe_w[3]), .o_parity_err(pe_w[3]), .o_overrun_err(oe_w[3]));

  // A commit is the busy falling edge that leaves rx_valid set.
  for (genvar g = 0; g < 4; g++) begin : g_mon
    logic pb = 1'b0;
    always @(negedge clk) begin
      if (rst_n && pb && !busy_w[g] && valid_w[g]) begin
        total++;
        if (exp_q[g].size() == 0) begin
          bad++;
          $error("FAIL unexpected_commit_u%0d got data=%h fe=%b pe=%b oe=%b required no commit",
                 g, data_w[g], fe_w[g], pe_w[g], oe_w[g]);
        end else begin
          automatic logic [10:0] e = exp_q[g].pop_front();
          assert ({oe_w[g], pe_w[g], fe_w[g], data_w[g]} === e) else begin
            bad++;
            $error("FAIL commit_u%0d got {oe,pe,fe,data}=%h required %h",
                   g, {oe_w[g], pe_w[g], fe_w[g], data_w[g]}, e);
          end
        end
      end
      pb <= busy_w[g];
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] req);
    total++;
    assert (got === req) else begin
      bad++;
      $error("FAIL %s got=%0h required=%0h", tag, got, req);
    end
  endtask

  // start bit, 8 data bits LSB first, then nt tail bits (parity/stop), rest idle
  function automatic logic [15:0] mk(input logic [7:0] d, input logic [3:0] tail, input int nt);
    logic [15:0] f;
    f      = 16'hFFFF;
    f[0]   = 1'b0;
    f[8:1] = d;
    for (int i = 0; i < nt; i++) f[9+i] = tail[i];
    return f;
  endfunction

  task automatic send(input int u, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      line[u] = f[i];
      cyc(B);
    end
    line[u] = 1'b1;
  endtask

  task automatic push(input int u, input logic [7:0] d, input logic fe, input logic pe, input logic oe);
    exp_q[u].push_back({oe, pe, fe, d});
  endtask

  task automatic do_ack(input int u, input string tag);
    ack[u] = 1'b1;
    cyc(1);
    ack[u] = 1'b0;
    chk(tag, valid_w[u], 1'b0);
  endtask

  initial begin
    logic sb, sv;
    cyc(3);
    for (int u = 0; u < 4; u++)
      chk($sformatf("reset_u%0d", u),
          {data_w[u], valid_w[u], busy_w[u], fe_w[u], pe_w[u], oe_w[u]}, 0);
    rst_n = 1'b1;
    cyc(4);

    // 8N1 0xA5 with latency measured from the falling line edge
    push(0, 8'hA5, 0, 0, 0);
    fork
      send(0, mk(8'hA5, 4'b0001, 1), 10);
      begin
        lat = 0;
        while (!valid_w[0] && lat < 1000) begin
          cyc(1);
          lat++;
        end
      end
    join
    chk("latency_a5_in_615_623", (lat >= 615 && lat <= 623), 1'b1);
    do_ack(0, "ack_clears_valid");

    // 12-cycle low pulse: false start
    sb = 1'b0;
    sv = 1'b0;
    line[0] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (i == 11) line[0] = 1'b1;
      sb |= busy_w[0];
      sv |= valid_w[0];
    end
    chk("glitch_busy_pulsed", sb, 1'b1);
    chk("glitch_no_valid", sv, 1'b0);
    chk("glitch_back_idle", busy_w[0], 1'b0);

    // one-cycle inverted glitch on the middle sample of data bit 2
    push(0, 8'h5A, 0, 0, 0);
    fork
      send(0, mk(8'h5A, 4'b0001, 1), 10);
      begin
        cyc(3*B + 36);
        line[0] = ~line[0];
        cyc(1);
        line[0] = ~line[0];
      end
    join
    do_ack(0, "ack_after_glitch_frame");

    // back-to-back without ack, then ack exactly on the commit cycle of 0x33
    push(0, 8'h11, 0, 0, 0);
    push(0, 8'h22, 0, 0, 1);
    send(0, mk(8'h11, 4'b0001, 1), 10);
    send(0, mk(8'h22, 4'b0001, 1), 10);
    chk("overrun_valid_held", valid_w[0], 1'b1);
    push(0, 8'h33, 0, 0, 0);
    fork
      send(0, mk(8'h33, 4'b0001, 1), 10);
      begin
        cyc(618);
        ack[0] = 1'b1;
        cyc(1);
        ack[0] = 1'b0;
      end
    join
    chk("simul_ack_valid_kept", valid_w[0], 1'b1);
    chk("simul_ack_data", data_w[0], 8'h33);
    do_ack(0, "ack_after_simul");

    // reset pulse in the middle of data bit 4 of 0xFF
    fork
      send(0, mk(8'hFF, 4'b0001, 1), 10);
      begin
        cyc(5*B + 20);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        chk("reset_mid_frame_outputs",
            {data_w[0], valid_w[0], busy_w[0], fe_w[0], pe_w[0], oe_w[0]}, 0);
      end
    join
    cyc(B);
    push(0, 8'h81, 0, 0, 0);
    send(0, mk(8'h81, 4'b0001, 1), 10);
    chk("after_reset_valid", valid_w[0], 1'b1);
    do_ack(0, "ack_after_reset_frame");

    // even parity: 0x03 has XOR 0, so parity bit 1 is wrong and 0 is right
    push(1, 8'h03, 0, 1, 0);
    send(1, mk(8'h03, 4'b0011, 2), 11);
    do_ack(1, "ack_8e1_bad");
    push(1, 8'h03, 0, 0, 0);
    send(1, mk(8'h03, 4'b0010, 2), 11);
    do_ack(1, "ack_8e1_good");

    // odd parity: 0x03 needs parity bit 1
    push(2, 8'h03, 0, 0, 0);
    send(2, mk(8'h03, 4'b0011, 2), 11);
    do_ack(2, "ack_8o1_good");
    push(2, 8'h03, 0, 1, 0);
    send(2, mk(8'h03, 4'b0010, 2), 11);
    do_ack(2, "ack_8o1_bad");

    // 8N2 with second stop bit low
    push(3, 8'h5A, 1, 0, 0);
    send(3, mk(8'h5A, 4'b0001, 2), 11);
    do_ack(3, "ack_8n2_frame_err");

    // break: line low for 20 bit periods gives exactly one zero/frame-error commit
    push(3, 8'h00, 1, 0, 0);
    line[3] = 1'b0;
    cyc(800);
    chk("break_commit_valid", valid_w[3], 1'b1);
    do_ack(3, "ack_break");
    cyc(20*B - 801);
    chk("break_no_second_commit", valid_w[3], 1'b0);
    line[3] = 1'b1;
    cyc(2*B);
    push(3, 8'hC3, 0, 0, 0);
    send(3, mk(8'hC3, 4'b0011, 2), 11);
    chk("after_break_valid", valid_w[3], 1'b1);
    do_ack(3, "ack_after_break");

    cyc(10);
    for (int u = 0; u < 4; u++)
      chk($sformatf("missing_commits_u%0d", u), exp_q[u].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
